// File: rtl/tt_sweep_checker_pkg.sv
// Shared state encodings, default sizing and helpers for the truth-table sweep checker.
package tt_sweep_checker_pkg;

  typedef enum logic [1:0] {
    TT_IDLE   = 2'd0,
    TT_SETTLE = 2'd1,
    TT_CHECK  = 2'd2,
    TT_DONE   = 2'd3
  } tt_state_e;

  localparam int TT_N_IN_DEFAULT   = 2;
  localparam int TT_SETTLE_DEFAULT = 1;

  // Counter width able to hold the value SETTLE itself.
  function automatic int tt_cnt_width(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/tt_sweep_checker_settle_timer.sv
// tt_settle_timer: loadable down-counter that flags ready once it reaches 1.
module tt_settle_timer
  import tt_sweep_checker_pkg::*;
#(
  parameter int SETTLE = TT_SETTLE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic ready_o
);

  localparam int W = tt_cnt_width(SETTLE);

  logic [W-1:0] cnt_q;

  assign ready_o = (cnt_q == W'(1));

  // Counting stops at 1 so ready stays asserted until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= W'(SETTLE);
    end else if (en_i && !ready_o) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

endmodule

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: clocked truth-table sweep comparing two implementations.
// Define TT_MISMATCH_MAP_EN to add the per-vector mismatch bitmap port mism_map.
module tt_sweep_checker
  import tt_sweep_checker_pkg::*;
#(
  parameter int N_IN   = TT_N_IN_DEFAULT,
  parameter int SETTLE = TT_SETTLE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   vec_out,
  input  logic              res_a,
  input  logic              res_b,
  output logic              busy,
  output logic              done,
  output logic              equal,
  output logic [N_IN:0]     mism_cnt,
  output logic              first_valid,
  output logic [N_IN-1:0]   first_bad
`ifdef TT_MISMATCH_MAP_EN
  ,
  output logic [2**N_IN-1:0] mism_map
`endif
);

  localparam int              CW      = N_IN + 1;
  localparam logic [N_IN-1:0] VEC_MAX = {N_IN{1'b1}};

  tt_state_e       state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [CW-1:0]   mism_cnt_q, mism_cnt_d;
  logic [CW-1:0]   cnt_upd;
  logic            first_valid_q, first_valid_d;
  logic [N_IN-1:0] first_bad_q, first_bad_d;
  logic            equal_q, equal_d;
  logic            mism;
  logic            timer_load, timer_en, timer_ready;
`ifdef TT_MISMATCH_MAP_EN
  logic [2**N_IN-1:0] map_q, map_d;
`endif

  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (timer_load),
    .en_i    (timer_en),
    .ready_o (timer_ready)
  );

  assign mism    = res_a ^ res_b;
  assign cnt_upd = mism_cnt_q + CW'(mism);

  always_comb begin
    state_d       = state_q;
    vec_d         = vec_q;
    mism_cnt_d    = mism_cnt_q;
    first_valid_d = first_valid_q;
    first_bad_d   = first_bad_q;
    equal_d       = equal_q;
    timer_load    = 1'b0;
    timer_en      = 1'b0;
`ifdef TT_MISMATCH_MAP_EN
    map_d         = map_q;
`endif
    case (state_q)
      TT_IDLE, TT_DONE: begin
        if (start) begin
          state_d       = TT_SETTLE;
          vec_d         = '0;
          mism_cnt_d    = '0;
          first_valid_d = 1'b0;
          first_bad_d   = '0;
          equal_d       = 1'b0;
          timer_load    = 1'b1;
`ifdef TT_MISMATCH_MAP_EN
          map_d         = '0;
`endif
        end
      end
      TT_SETTLE: begin
        timer_en = 1'b1;
        if (timer_ready) state_d = TT_CHECK;
      end
      TT_CHECK: begin
        if (mism) begin
          mism_cnt_d = cnt_upd;
`ifdef TT_MISMATCH_MAP_EN
          map_d[vec_q] = 1'b1;
`endif
          if (!first_valid_q) begin
            first_bad_d   = vec_q;
            first_valid_d = 1'b1;
          end
        end
        // The last vector ends the sweep; vec_out is never allowed to wrap.
        if (vec_q == VEC_MAX) begin
          state_d = TT_DONE;
          equal_d = (cnt_upd == '0);
        end else begin
          state_d    = TT_SETTLE;
          vec_d      = vec_q + N_IN'(1);
          timer_load = 1'b1;
        end
      end
      default: state_d = TT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= TT_IDLE;
      vec_q         <= '0;
      mism_cnt_q    <= '0;
      first_valid_q <= 1'b0;
      first_bad_q   <= '0;
      equal_q       <= 1'b0;
`ifdef TT_MISMATCH_MAP_EN
      map_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      vec_q         <= vec_d;
      mism_cnt_q    <= mism_cnt_d;
      first_valid_q <= first_valid_d;
      first_bad_q   <= first_bad_d;
      equal_q       <= equal_d;
`ifdef TT_MISMATCH_MAP_EN
      map_q         <= map_d;
`endif
    end
  end

  assign vec_out     = vec_q;
  assign busy        = (state_q == TT_SETTLE) || (state_q == TT_CHECK);
  assign done        = (state_q == TT_DONE);
  assign equal       = equal_q;
  assign mism_cnt    = mism_cnt_q;
  assign first_valid = first_valid_q;
  assign first_bad   = first_bad_q;
`ifdef TT_MISMATCH_MAP_EN
  assign mism_map    = map_q;
`endif

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench for tt_sweep_checker: two instances (N_IN=2/SETTLE=1 and N_IN=3/SETTLE=3).
module tb_tt_sweep_checker;

  typedef struct {
    logic [3:0] cnt;
    logic       fv;
    logic [2:0] fb;
    logic       eq;
    logic [7:0] map;
    int         done_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Instance 0: N_IN=2, SETTLE=1
  logic       rst0 = 1'b1, start0 = 1'b0;
  logic [1:0] vec0;
  logic       res_a0, res_b0;
  logic       busy0, done0, equal0, fv0;
  logic [2:0] cnt0;
  logic [1:0] fb0;
  int         mode0 = 0;
`ifdef TT_MISMATCH_MAP_EN
  logic [3:0] map0;
`endif

  // Instance 1: N_IN=3, SETTLE=3, res_a=1, res_b=0
  logic       rst1 = 1'b1, start1 = 1'b0;
  logic [2:0] vec1;
  logic       busy1, done1, equal1, fv1;
  logic [3:0] cnt1;
  logic [2:0] fb1;
`ifdef TT_MISMATCH_MAP_EN
  logic [7:0] map1;
`endif

  always_comb begin
    res_a0 = 1'b0;
    res_b0 = 1'b0;
    if (mode0 == 0) begin
      res_a0 = ~vec0[1] & vec0[0];
      res_b0 = ~vec0[1] & ~vec0[0];
    end else begin
      res_a0 = ~(vec0[1] | vec0[0]);
      res_b0 = ~(vec0[1] | vec0[0]);
    end
  end

  tt_sweep_checker #(.N_IN(2), .SETTLE(1)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .vec_out(vec0),
    .res_a(res_a0), .res_b(res_b0), .busy(busy0), .done(done0),
    .equal(equal0), .mism_cnt(cnt0), .first_valid(fv0), .first_bad(fb0)
`ifdef TT_MISMATCH_MAP_EN
    , .mism_map(map0)
`endif
  );

  tt_sweep_checker #(.N_IN(3), .SETTLE(3)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .vec_out(vec1),
    .res_a(1'b1), .res_b(1'b0), .busy(busy1), .done(done1),
    .equal(equal1), .mism_cnt(cnt1), .first_valid(fv1), .first_bad(fb1)
`ifdef TT_MISMATCH_MAP_EN
    , .mism_map(map1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop one expectation whenever done rises.
  logic done0_prev = 1'b0;
  always @(negedge clk) begin
    if (done0 && !done0_prev) begin
      if (q0.size() == 0) begin
        chk("dut0_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("dut0_done_cycle", cyc, e.done_cyc);
        chk("dut0_mism_cnt", {29'd0, cnt0}, {28'd0, e.cnt});
        chk("dut0_first_valid", {31'd0, fv0}, {31'd0, e.fv});
        chk("dut0_first_bad", {30'd0, fb0}, {29'd0, e.fb});
        chk("dut0_equal", {31'd0, equal0}, {31'd0, e.eq});
        chk("dut0_busy_in_done", {31'd0, busy0}, 32'd0);
`ifdef TT_MISMATCH_MAP_EN
        chk("dut0_mism_map", {28'd0, map0}, {24'd0, e.map});
`endif
        $display("dut0 sweep done at cycle %0d: mism_cnt=%0d first_bad=%0d equal=%0d", cyc, cnt0, fb0, equal0);
      end
    end
    done0_prev <= done0;
  end

  logic done1_prev = 1'b0;
  always @(negedge clk) begin
    if (done1 && !done1_prev) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1_done_cycle", cyc, e.done_cyc);
        chk("dut1_mism_cnt", {28'd0, cnt1}, {28'd0, e.cnt});
        chk("dut1_first_valid", {31'd0, fv1}, {31'd0, e.fv});
        chk("dut1_first_bad", {29'd0, fb1}, {29'd0, e.fb});
        chk("dut1_equal", {31'd0, equal1}, {31'd0, e.eq});
`ifdef TT_MISMATCH_MAP_EN
        chk("dut1_mism_map", {24'd0, map1}, {24'd0, e.map});
`endif
        $display("dut1 sweep done at cycle %0d: mism_cnt=%0d first_bad=%0d equal=%0d", cyc, cnt1, fb1, equal1);
      end
    end
    done1_prev <= done1;
  end

  // Drive start for one cycle; leaves the caller at the negedge after the sampling edge.
  task automatic start0_pulse(input logic push, input exp_t e);
    @(negedge clk);
    start0 = 1'b1;
    e.done_cyc = cyc + 1 + 4 * 2;
    if (push) q0.push_back(e);
    $display("dut0 start issued at cycle %0d, expect done at %0d", cyc, e.done_cyc);
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic drain(input int which, input int budget);
    int n = 0;
    while (((which == 0) ? q0.size() : q1.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (((which == 0) ? q0.size() : q1.size()) != 0) begin
      chk($sformatf("dut%0d_done_timeout", which), 32'd0, 32'd1);
      if (which == 0) q0.delete(); else q1.delete();
    end
  endtask

  initial begin
    exp_t e;
    int n;

    // 1. Reset then idle
    rst0 = 1'b1; rst1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vec_out", {30'd0, vec0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_equal", {31'd0, equal0}, 32'd0);
    chk("rst_mism_cnt", {29'd0, cnt0}, 32'd0);
    chk("rst_first_valid", {31'd0, fv0}, 32'd0);
    chk("rst_first_bad", {30'd0, fb0}, 32'd0);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy0}, 32'd0);
    chk("idle_done", {31'd0, done0}, 32'd0);

    // 2. Mismatch sweep: vectors 00 and 01 differ
    mode0 = 0;
    e = '{cnt: 4'd2, fv: 1'b1, fb: 3'd0, eq: 1'b0, map: 8'h03, done_cyc: 0};
    start0_pulse(1'b1, e);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("sweep_vec_j%0d", j), {30'd0, vec0}, j / 2);
      @(negedge clk);
    end
    drain(0, 20);

    // 3+4. Equivalent sweep started from DONE; a mid-sweep start must be ignored
    mode0 = 1;
    e = '{cnt: 4'd0, fv: 1'b0, fb: 3'd0, eq: 1'b1, map: 8'h00, done_cyc: 0};
    start0_pulse(1'b1, e);
    chk("restart_done_cleared", {31'd0, done0}, 32'd0);
    chk("restart_busy", {31'd0, busy0}, 32'd1);
    chk("restart_cnt_cleared", {29'd0, cnt0}, 32'd0);
    chk("restart_fv_cleared", {31'd0, fv0}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    drain(0, 20);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("hold_done_%0d", k), {31'd0, done0}, 32'd1);
      chk($sformatf("hold_equal_%0d", k), {31'd0, equal0}, 32'd1);
    end

    // 5. Reset mid-sweep while vec_out=10 (aborted sweep, nothing pushed)
    mode0 = 0;
    start0_pulse(1'b0, e);
    n = 0;
    while (vec0 != 2'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reached_vec2", {30'd0, vec0}, 32'd2);
    chk("midrst_cnt_before", {29'd0, cnt0}, 32'd2);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    chk("midrst_vec_out", {30'd0, vec0}, 32'd0);
    chk("midrst_mism_cnt", {29'd0, cnt0}, 32'd0);
    chk("midrst_busy", {31'd0, busy0}, 32'd0);
    chk("midrst_done", {31'd0, done0}, 32'd0);
    repeat (12) @(negedge clk);
    chk("midrst_stays_idle", {31'd0, busy0 | done0}, 32'd0);

    // 6. N_IN=3, SETTLE=3, every vector mismatches
    @(negedge clk);
    start1 = 1'b1;
    e = '{cnt: 4'd8, fv: 1'b1, fb: 3'd0, eq: 1'b0, map: 8'hFF, done_cyc: cyc + 1 + 8 * 4};
    q1.push_back(e);
    $display("dut1 start issued at cycle %0d, expect done at %0d", cyc, e.done_cyc);
    @(negedge clk);
    start1 = 1'b0;
    chk("dut1_busy_after_start", {31'd0, busy1}, 32'd1);
    drain(1, 60);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
